mult_ctrl: RTL

Control FSM for the shift-add multiplier datapath. It sequences the RESET, ADD and SHIFT strobes into the 9-bit accumulator/multiplier register. It reads the register LSB (current multiplier bit) to decide between add-then-shift and shift-only. It provides a start/busy/done handshake to the system-level sequencer.

---
 rtl/mult_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/mult_ctrl.sv
// Control FSM for the shift-add multiplier: sequences the load, add and shift
// strobes into the accumulator/multiplier register and handshakes with the sequencer.
module mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     clear,
  input  logic                     q0,
  output logic                     RESET,
  output logic                     ADD,
  output logic                     SHIFT,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] count
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    TEST   = 3'd2,
    ADDS   = 3'd3,
    SHIFTS = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, next_state;

  // count saturates at LAST and is held through DONE so the final iteration stays visible
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (clear)
        count <= '0;
      else if (state == INIT)
        count <= '0;
      else if (state == SHIFTS && count != LAST)
        count <= count + CW'(1);
    end
  end

  always_comb begin
    next_state = IDLE;
    RESET      = 1'b0;
    ADD        = 1'b0;
    SHIFT      = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    next_state = start ? INIT : IDLE;
      INIT: begin
        RESET      = 1'b1;
        next_state = TEST;
      end
      TEST:    next_state = q0 ? ADDS : SHIFTS;
      ADDS: begin
        ADD        = 1'b1;
        next_state = SHIFTS;
      end
      SHIFTS: begin
        SHIFT      = 1'b1;
        next_state = (count == LAST) ? DONE : TEST;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // abort wins over every transition, including a start seen in IDLE
    if (clear)
      next_state = IDLE;
  end

endmodule
